// File: rtl/sb_client_fsm_pkg.sv
// sb_client_fsm_pkg: opcodes, state encoding and clog2 helper shared by the scoreboard client.
package sb_client_fsm_pkg;

    localparam logic [1:0] MEM_OPCODE_READ       = 2'b00;
    localparam logic [1:0] MEM_OPCODE_WRITE_ADDR = 2'b01;
    localparam logic [1:0] ACCEL_OPCODE          = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_GNT,
        RD_ACK,
        ACC_REQ,
        ACC_GNT,
        ACC_ACK,
        WA_REQ,
        WA_GNT,
        WA_ACK
    } sb_client_state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sb_client_fsm.sv
// sb_client_fsm: walks one job through scoreboard READ -> accelerator -> WRITE_ADDR phases.
// Optional watchdog (err pulse, abort to IDLE) enabled by defining SB_CLIENT_TIMEOUT_EN.
module sb_client_fsm
    import sb_client_fsm_pkg::*;
#(
    parameter int SRC_ID_W       = 4,
    parameter int OPCODE_W       = 2,
    parameter int MY_SRC_ID      = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [SRC_ID_W-1:0] req_src_id,
    output logic [OPCODE_W-1:0] req_opcode,
    input  logic                mem_ready,
    input  logic                grant_valid,
    input  logic [SRC_ID_W-1:0] grant_mem_id,
    input  logic [SRC_ID_W-1:0] grant_accel_id,
    input  logic                ack_valid,
    input  logic [SRC_ID_W-1:0] ack_src_id,
    output logic                busy,
    output logic                done,
    output logic                err
);

    sb_client_state_e    state_q, state_d, state_n;
    logic [SRC_ID_W-1:0] id_q, id_d;
    logic                done_q, done_d;
    logic                ack_hit;
    logic [1:0]          op;

    assign ack_hit    = ack_valid && (ack_src_id == id_q);
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    // The done cycle already sits in IDLE, so it is kept out of cmd_ready explicitly.
    assign cmd_ready  = (state_q == IDLE) && !done_q;
    assign req_src_id = SRC_ID_W'(MY_SRC_ID);
    assign req_opcode = OPCODE_W'(op);
    assign done_d     = (state_q == WA_ACK) && ack_hit;

    always_comb begin
        op = (state_q inside {ACC_REQ, ACC_GNT, ACC_ACK}) ? ACCEL_OPCODE :
             (state_q inside {WA_REQ, WA_GNT, WA_ACK})    ? MEM_OPCODE_WRITE_ADDR : MEM_OPCODE_READ;
        id_d = !grant_valid                                ? id_q :
               (state_q == RD_GNT || state_q == WA_GNT)    ? grant_mem_id :
               (state_q == ACC_GNT)                        ? grant_accel_id : id_q;
    end

    always_comb begin
        state_n   = state_q;
        req_valid = 1'b0;
        case (state_q)
            IDLE:    state_n = cmd_valid && cmd_ready ? RD_REQ : IDLE;
            RD_REQ: begin
                req_valid = mem_ready;
                state_n   = mem_ready && req_ready ? RD_GNT : RD_REQ;
            end
            RD_GNT:  state_n = grant_valid ? RD_ACK : RD_REQ;
            RD_ACK:  state_n = ack_hit ? ACC_REQ : RD_ACK;
            ACC_REQ: begin
                req_valid = 1'b1;
                state_n   = req_ready ? ACC_GNT : ACC_REQ;
            end
            ACC_GNT: state_n = grant_valid ? ACC_ACK : ACC_REQ;
            ACC_ACK: state_n = ack_hit ? WA_REQ : ACC_ACK;
            WA_REQ: begin
                req_valid = mem_ready;
                state_n   = mem_ready && req_ready ? WA_GNT : WA_REQ;
            end
            WA_GNT:  state_n = grant_valid ? WA_ACK : WA_REQ;
            WA_ACK:  state_n = ack_hit ? IDLE : WA_ACK;
            default: state_n = IDLE;
        endcase
    end

`ifdef SB_CLIENT_TIMEOUT_EN
    localparam int                CNT_W = safe_clog2(TIMEOUT_CYCLES);
    // Counter reads 0 on entry, so matching LIMIT lands the err pulse on count TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, expire;

    assign expire  = (state_q != IDLE) && (state_n == state_q) && (cnt_q == LIMIT);
    assign state_d = expire ? IDLE : state_n;
    assign cnt_d   = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + 1'b1;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= expire;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign state_d        = state_n;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sb_client_fsm.sv
// tb_sb_client_fsm: directed scoreboard-driven bench for sb_client_fsm (MY_SRC_ID=3, TIMEOUT_CYCLES=16).
module tb_sb_client_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       req_ready = 1'b1;
    logic       mem_ready = 1'b1;
    logic       grant_valid = 1'b0;
    logic       ack_valid = 1'b0;
    logic [3:0] grant_mem_id = 4'h0;
    logic [3:0] grant_accel_id = 4'h0;
    logic [3:0] ack_src_id = 4'h0;
    logic [3:0] req_src_id;
    logic [1:0] req_opcode;
    logic       cmd_ready, req_valid, busy, done, err;

    logic [1:0] exp_q[$];
    int n_vec = 0;
    int n_mis = 0;
    int ncyc = 0;
    int ndone = 0;
    int a = 0;
    int d0 = 0;

    always #5 clk = ~clk;

    sb_client_fsm #(
        .SRC_ID_W(4), .OPCODE_W(2), .MY_SRC_ID(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_id(req_src_id), .req_opcode(req_opcode),
        .mem_ready(mem_ready),
        .grant_valid(grant_valid), .grant_mem_id(grant_mem_id), .grant_accel_id(grant_accel_id),
        .ack_valid(ack_valid), .ack_src_id(ack_src_id),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pop_exp();
        if (exp_q.size() == 0) return 2'bxx;
        return exp_q.pop_front();
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
        ncyc++;
        if (done) ndone++;
    endtask

    task automatic start_job(input int acc_tries);
        exp_q.push_back(2'b00);
        repeat (acc_tries) exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        cyc();
        cmd_valid = 1'b0;
        a = ncyc;
    endtask

    task automatic phase(input bit acc, input logic [3:0] gid, input int stall,
                         input int retries, input bit bad_ack, input bit no_ack);
        mem_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            chk("stall_req_valid", 32'(req_valid), 0);
            chk("stall_busy", 32'(busy), 1);
            cyc();
        end
        mem_ready = 1'b1;
        for (int r = 0; r <= retries; r++) begin
            #1;
            chk("req_valid", 32'(req_valid), 1);
            chk("req_opcode", 32'(req_opcode), 32'(pop_exp()));
            cyc();
            grant_valid    = (r == retries);
            grant_mem_id   = acc ? ~gid : gid;
            grant_accel_id = acc ? gid : ~gid;
            #1;
            chk("gnt_req_valid", 32'(req_valid), 0);
            cyc();
            grant_valid = 1'b0;
            if (r < retries) begin
                #1;
                chk("retry_err", 32'(err), 0);
            end
        end
        #1;
        chk("ack_wait_req_valid", 32'(req_valid), 0);
        if (bad_ack) begin
            ack_valid  = 1'b1;
            ack_src_id = gid ^ 4'h2;
            cyc();
            #1;
            chk("bad_ack_ignored", 32'(req_valid), 0);
            chk("bad_ack_busy", 32'(busy), 1);
        end
        if (!no_ack) begin
            ack_valid  = 1'b1;
            ack_src_id = gid;
            cyc();
        end
        ack_valid = 1'b0;
    endtask

    task automatic check_done(input int jobs);
        #1;
        chk("done_pulse", 32'(done), 1);
        chk("done_cmd_ready", 32'(cmd_ready), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_count", ndone, jobs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_opcode", 32'(req_opcode), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("src_id", 32'(req_src_id), 3);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Job 1: zero-wait happy path, grants mem=5, accel=9, mem=6.
        start_job(1);
        phase(1'b0, 4'd5, 0, 0, 1'b0, 1'b0);
        phase(1'b1, 4'd9, 0, 0, 1'b0, 1'b0);
        phase(1'b0, 4'd6, 0, 0, 1'b0, 1'b0);
        check_done(1);
        chk("latency", ncyc - a, 9);
        cmd_valid = 1'b1;
        cyc();
        #1;
        chk("done_cycle_not_accepted", 32'(busy), 0);
        chk("cmd_ready_back", 32'(cmd_ready), 1);
        chk("done_single", 32'(done), 0);

        // Job 2: mem_ready stall, ack filtering, accelerator grant retry.
        start_job(2);
        phase(1'b0, 4'd5, 5, 0, 1'b1, 1'b0);
        phase(1'b1, 4'd9, 0, 1, 1'b0, 1'b0);
        phase(1'b0, 4'd6, 0, 0, 1'b0, 1'b0);
        check_done(2);
        chk("job2_err", 32'(err), 0);

        // Job 3: async reset between edges while in ACC_ACK.
        cyc();
        start_job(1);
        phase(1'b0, 4'd4, 0, 0, 1'b0, 1'b0);
        phase(1'b1, 4'd8, 0, 0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_req_valid", 32'(req_valid), 0);
        chk("arst_cmd_ready", 32'(cmd_ready), 1);
        d0 = ndone;
        cyc();
        cyc();
        rst_n = 1'b1;
        chk("arst_no_done", ndone, d0);
        chk("arst_no_err", 32'(err), 0);
        exp_q.delete();

        // Job 4: restart after reset runs from RD_REQ.
        start_job(1);
        phase(1'b0, 4'd2, 0, 0, 1'b0, 1'b0);
        phase(1'b1, 4'd1, 0, 0, 1'b0, 1'b0);
        phase(1'b0, 4'd7, 0, 0, 1'b0, 1'b0);
        check_done(3);

`ifdef SB_CLIENT_TIMEOUT_EN
        // Job 5: WA_ACK never acked, watchdog aborts.
        cyc();
        start_job(1);
        phase(1'b0, 4'd5, 0, 0, 1'b0, 1'b0);
        phase(1'b1, 4'd9, 0, 0, 1'b0, 1'b0);
        phase(1'b0, 4'd6, 0, 0, 1'b0, 1'b1);
        a = ncyc;
        d0 = ndone;
        for (int t = 0; t < 40 && !err; t++) cyc();
        #1;
        chk("timeout_err", 32'(err), 1);
        chk("timeout_cycles", ncyc - a, 15);
        chk("timeout_idle", 32'(busy), 0);
        chk("timeout_no_done", ndone, d0);
        cyc();
        #1;
        chk("timeout_err_single", 32'(err), 0);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
